fifo_sync_dwc: RTL and testbench



---
 rtl/fifo_sync_dwc_if.sv | 31 +++
 rtl/fifo_sync_dwc.sv | 90 +++++++++
 tb/tb_fifo_sync_dwc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_dwc_if.sv
// fifo_sync_dwc_if: write/read handshake bundle for the width-converting FIFO.
// FIFO_DWC_WATERMARK_EN adds the max_num peak-occupancy signal.
interface fifo_sync_dwc_if #(
    parameter int WBITS = 32,
    parameter int RBITS = 8,
    parameter int ABITS = 10
);
    logic             wren;
    logic [WBITS-1:0] wr_data;
    logic             rden;
    logic [RBITS-1:0] rd_data;
    logic             wrfull;
    logic             rdempty;
    logic             almost_full;
    logic             almost_empty;
    logic             wr_ovf;
    logic             rd_udf;
    logic [ABITS:0]   fifo_num;
`ifdef FIFO_DWC_WATERMARK_EN
    logic [ABITS:0]   max_num;
    modport master(output wren, wr_data, rden,
                   input rd_data, wrfull, rdempty, almost_full, almost_empty, wr_ovf, rd_udf, fifo_num, max_num);
    modport slave(input wren, wr_data, rden,
                  output rd_data, wrfull, rdempty, almost_full, almost_empty, wr_ovf, rd_udf, fifo_num, max_num);
`else
    modport master(output wren, wr_data, rden,
                   input rd_data, wrfull, rdempty, almost_full, almost_empty, wr_ovf, rd_udf, fifo_num);
    modport slave(input wren, wr_data, rden,
                  output rd_data, wrfull, rdempty, almost_full, almost_empty, wr_ovf, rd_udf, fifo_num);
`endif
endinterface

// File: rtl/fifo_sync_dwc.sv
// fifo_sync_dwc: single-clock FIFO with power-of-2 write/read width conversion, little-endian unit order.
// FIFO_DWC_WATERMARK_EN adds the max_num peak-occupancy output.
module fifo_sync_dwc #(
    parameter int WBITS     = 32,
    parameter int RBITS     = 8,
    parameter int ABITS     = 10,
    parameter int SHOWAHEAD = 0,
    parameter int FTHRD     = 900,
    parameter int ETHRD     = 2
) (
    input  logic           clk,
    input  logic           rst,
    fifo_sync_dwc_if.slave bus
);
    localparam int U  = (WBITS < RBITS) ? WBITS : RBITS;
    localparam int WU = WBITS / U;
    localparam int RU = RBITS / U;
    localparam logic [ABITS:0] WU_N    = (ABITS+1)'(WU);
    localparam logic [ABITS:0] RU_N    = (ABITS+1)'(RU);
    localparam logic [ABITS:0] DEPTH_N = (ABITS+1)'(2**ABITS);
    localparam logic [ABITS:0] FTH_N   = (ABITS+1)'(FTHRD);
    localparam logic [ABITS:0] ETH_N   = (ABITS+1)'(ETHRD);

    logic [U-1:0]     mem_q [2**ABITS];
    logic [ABITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [ABITS:0]   num_q, num_d;
    logic [RBITS-1:0] head, rd_data_q;
    logic             wrfull_q, rdempty_q, af_q, ae_q, ovf_q, udf_q;
    logic             wr_acc, rd_acc;

    assign wr_acc = bus.wren && !wrfull_q;
    assign rd_acc = bus.rden && !rdempty_q;
    assign num_d  = num_q + (wr_acc ? WU_N : '0) - (rd_acc ? RU_N : '0);

    // Read side gathers RU consecutive units starting at the aligned read pointer
    always_comb begin
        head = '0;
        for (int j = 0; j < RU; j++) head[j*U +: U] = mem_q[rd_ptr_q + ABITS'(j)];
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            for (int i = 0; i < WU; i++) mem_q[wr_ptr_q + ABITS'(i)] <= bus.wr_data[i*U +: U];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            num_q     <= '0;
            rd_data_q <= '0;
            wrfull_q  <= 1'b0;
            rdempty_q <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + ABITS'(WU);
            if (rd_acc) wr_ptr_q <= wr_acc ? wr_ptr_q + ABITS'(WU) : wr_ptr_q;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + ABITS'(RU);
            if (rd_acc) rd_data_q <= head;
            num_q     <= num_d;
            wrfull_q  <= (DEPTH_N - num_d) < WU_N;
            rdempty_q <= num_d < RU_N;
            af_q      <= num_d >= FTH_N;
            ae_q      <= num_d <= ETH_N;
            ovf_q     <= bus.wren && wrfull_q;
            udf_q     <= bus.rden && rdempty_q;
        end
    end

    assign bus.rd_data      = (SHOWAHEAD != 0) ? head : rd_data_q;
    assign bus.wrfull       = wrfull_q;
    assign bus.rdempty      = rdempty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.wr_ovf       = ovf_q;
    assign bus.rd_udf       = udf_q;
    assign bus.fifo_num     = num_q;

`ifdef FIFO_DWC_WATERMARK_EN
    logic [ABITS:0] max_q;
    always_ff @(posedge clk) begin
        if (rst) max_q <= '0;
        else if (num_d > max_q) max_q <= num_d;
    end
    assign bus.max_num = max_q;
`endif
endmodule

// File: tb/tb_fifo_sync_dwc.sv
// tb_fifo_sync_dwc: directed vector bench for the width-converting FIFO.
// Three instances: 32->8 registered, 32->8 showahead, 8->32 registered.
module tb_fifo_sync_dwc;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   total = 0, passed = 0;

    always #5 clk = ~clk;

    fifo_sync_dwc_if #(.WBITS(32), .RBITS(8),  .ABITS(10)) if0();
    fifo_sync_dwc_if #(.WBITS(32), .RBITS(8),  .ABITS(10)) if1();
    fifo_sync_dwc_if #(.WBITS(8),  .RBITS(32), .ABITS(10)) if2();

    fifo_sync_dwc #(.WBITS(32), .RBITS(8), .ABITS(10), .SHOWAHEAD(0)) dut0(.clk(clk), .rst(rst0), .bus(if0.slave));
    fifo_sync_dwc #(.WBITS(32), .RBITS(8), .ABITS(10), .SHOWAHEAD(1)) dut1(.clk(clk), .rst(rst1), .bus(if1.slave));
    fifo_sync_dwc #(.WBITS(8), .RBITS(32), .ABITS(10), .SHOWAHEAD(0)) dut2(.clk(clk), .rst(rst2), .bus(if2.slave));

    typedef struct {
        logic        wren;
        logic [31:0] wd;
        logic        rden;
        logic [7:0]  rd;
        logic [10:0] num;
        logic        empty;
        logic        udf;
    } vec_t;
    vec_t v[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wbyte, rbyte, errs, cyc;
        v[0] = '{1'b1, 32'h44332211, 1'b0, 8'h00, 11'd4, 1'b0, 1'b0};
        v[1] = '{1'b0, 32'h0,        1'b1, 8'h11, 11'd3, 1'b0, 1'b0};
        v[2] = '{1'b0, 32'h0,        1'b1, 8'h22, 11'd2, 1'b0, 1'b0};
        v[3] = '{1'b0, 32'h0,        1'b1, 8'h33, 11'd1, 1'b0, 1'b0};
        v[4] = '{1'b0, 32'h0,        1'b1, 8'h44, 11'd0, 1'b1, 1'b0};
        v[5] = '{1'b0, 32'h0,        1'b0, 8'h44, 11'd0, 1'b1, 1'b0};
        v[6] = '{1'b0, 32'h0,        1'b1, 8'h44, 11'd0, 1'b1, 1'b1};
        v[7] = '{1'b0, 32'h0,        1'b0, 8'h44, 11'd0, 1'b1, 1'b0};
        {if0.wren, if0.rden, if0.wr_data} = '0;
        {if1.wren, if1.rden, if1.wr_data} = '0;
        {if2.wren, if2.rden, if2.wr_data} = '0;
        {rst0, rst1, rst2} = 3'b111;
        tick;
        tick;
        {rst0, rst1, rst2} = 3'b000;

        chk("rst_num", 32'(if0.fifo_num), 32'd0);
        chk("rst_empty", 32'(if0.rdempty), 32'd1);
        chk("rst_aempty", 32'(if0.almost_empty), 32'd1);
        chk("rst_full", 32'(if0.wrfull), 32'd0);
        chk("rst_afull", 32'(if0.almost_full), 32'd0);
        chk("rst_rdata", 32'(if0.rd_data), 32'd0);
        chk("rst_ovf", 32'(if0.wr_ovf), 32'd0);
        chk("rst_udf", 32'(if0.rd_udf), 32'd0);

        for (int i = 0; i < 8; i++) begin
            if0.wren = v[i].wren;
            if0.wr_data = v[i].wd;
            if0.rden = v[i].rden;
            tick;
            if0.wren = 1'b0;
            if0.rden = 1'b0;
            chk($sformatf("v%0d_rdata", i), 32'(if0.rd_data), 32'(v[i].rd));
            chk($sformatf("v%0d_num", i), 32'(if0.fifo_num), 32'(v[i].num));
            chk($sformatf("v%0d_empty", i), 32'(if0.rdempty), 32'(v[i].empty));
            chk($sformatf("v%0d_udf", i), 32'(if0.rd_udf), 32'(v[i].udf));
        end

        for (int k = 1; k <= 256; k++) begin
            if0.wren = 1'b1;
            if0.wr_data = 32'(k);
            tick;
            if (k == 224) chk("afull_896", 32'(if0.almost_full), 32'd0);
            if (k == 225) chk("afull_900", 32'(if0.almost_full), 32'd1);
            if (k == 255) chk("wrfull_1020", 32'(if0.wrfull), 32'd0);
        end
        chk("full_num", 32'(if0.fifo_num), 32'd1024);
        chk("full_flag", 32'(if0.wrfull), 32'd1);
        chk("full_afull", 32'(if0.almost_full), 32'd1);
        chk("full_ovf_pre", 32'(if0.wr_ovf), 32'd0);
        if0.wr_data = 32'hDEADBEEF;
        tick;
        if0.wren = 1'b0;
        chk("ovf_pulse", 32'(if0.wr_ovf), 32'd1);
        chk("ovf_num", 32'(if0.fifo_num), 32'd1024);
        tick;
        chk("ovf_clear", 32'(if0.wr_ovf), 32'd0);

        if1.wren = 1'b1;
        if1.wr_data = 32'h44332211;
        tick;
        chk("sa_num4", 32'(if1.fifo_num), 32'd4);
        chk("sa_head", 32'(if1.rd_data), 32'h11);
        if1.wr_data = 32'h88776655;
        if1.rden = 1'b1;
        tick;
        if1.wren = 1'b0;
        chk("sa_num7", 32'(if1.fifo_num), 32'd7);
        chk("sa_next", 32'(if1.rd_data), 32'h22);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("sa_rd%0d", i), 32'(if1.rd_data), 32'h33 + 32'(i) * 32'h11);
        end
        if1.rden = 1'b0;

        if2.wren = 1'b1;
        if2.wr_data = 8'hA1;
        tick;
        if2.wr_data = 8'hB2;
        tick;
        if2.wr_data = 8'hC3;
        tick;
        if2.wren = 1'b0;
        chk("up_empty3", 32'(if2.rdempty), 32'd1);
        chk("up_num3", 32'(if2.fifo_num), 32'd3);
        if2.rden = 1'b1;
        tick;
        if2.rden = 1'b0;
        chk("up_udf", 32'(if2.rd_udf), 32'd1);
        chk("up_udf_num", 32'(if2.fifo_num), 32'd3);
        if2.wren = 1'b1;
        if2.wr_data = 8'hD4;
        tick;
        if2.wren = 1'b0;
        chk("up_empty4", 32'(if2.rdempty), 32'd0);
        if2.rden = 1'b1;
        tick;
        if2.rden = 1'b0;
        chk("up_word", if2.rd_data, 32'hD4C3B2A1);
        chk("up_num0", 32'(if2.fifo_num), 32'd0);
        chk("up_empty0", 32'(if2.rdempty), 32'd1);

        if0.rden = 1'b1;
        for (int i = 0; i < 424; i++) tick;
        if0.rden = 1'b0;
        chk("mid_num600", 32'(if0.fifo_num), 32'd600);
        rst0 = 1'b1;
        if0.wren = 1'b1;
        tick;
        rst0 = 1'b0;
        if0.wren = 1'b0;
        chk("mrst_num", 32'(if0.fifo_num), 32'd0);
        chk("mrst_empty", 32'(if0.rdempty), 32'd1);
        chk("mrst_rdata", 32'(if0.rd_data), 32'd0);

        wbyte = 0;
        rbyte = 0;
        errs = 0;
        cyc = 0;
        while (rbyte < 2000 && cyc < 6000) begin
            logic wr, rd;
            wr = (wbyte < 2000) && !if0.wrfull;
            rd = !if0.rdempty;
            if0.wren = wr;
            if0.rden = rd;
            if0.wr_data = {8'(wbyte + 3), 8'(wbyte + 2), 8'(wbyte + 1), 8'(wbyte)};
            tick;
            cyc++;
            if (wr) wbyte += 4;
            if (rd) begin
                if (if0.rd_data !== 8'(rbyte)) errs++;
                rbyte++;
            end
        end
        if0.wren = 1'b0;
        if0.rden = 1'b0;
        chk("stream_count", 32'(rbyte), 32'd2000);
        chk("stream_errs", 32'(errs), 32'd0);
        chk("stream_num", 32'(if0.fifo_num), 32'd0);

`ifdef FIFO_DWC_WATERMARK_EN
        rst0 = 1'b1;
        tick;
        rst0 = 1'b0;
        if0.wren = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        if0.wren = 1'b0;
        if0.rden = 1'b1;
        for (int i = 0; i < 40; i++) tick;
        if0.rden = 1'b0;
        chk("wm_num", 32'(if0.fifo_num), 32'd0);
        chk("wm_max", 32'(if0.max_num), 32'd40);
        rst0 = 1'b1;
        tick;
        rst0 = 1'b0;
        chk("wm_rst", 32'(if0.max_num), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
